// File: rtl/pcc_circuit_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcc_pkg
// Description : Shared types and helpers for the PCC circuit allocator.
//               Provides the per-output state encoding, a one-hot test
//               for destination vectors and an index-to-one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package pcc_pkg;

  // Helpers operate on a fixed 32-bit vector; callers zero-extend narrower
  // vectors and truncate results back to their own width.
  localparam int VEC_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    TEARDOWN = 2'd2
  } out_state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  // Single bit set at position idx.
  function automatic logic [VEC_W-1:0] idx_to_onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcc_circuit_allocator_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pcc_rr_arbiter
// Description : Round-robin arbiter for one allocator output. Searches the
//               request vector starting at the stored pointer and returns a
//               one-hot grant plus its index; the pointer moves to the slot
//               after the winner whenever a grant is produced.
// Ports       : clk, reset (async, active-low)
//               req_i       [PORTS]  requests for this output
//               gnt_o       [PORTS]  one-hot grant (combinational)
//               gnt_idx_o   [IDXW]   index of the granted requester
//               gnt_valid_o          a grant is present this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pcc_rr_arbiter
  import pcc_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IDXW  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PORTS-1:0]  req_i,
  output logic [PORTS-1:0]  gnt_o,
  output logic [IDXW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] ptr_d;
  logic [IDXW:0]   slot;
  logic            found;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    found       = 1'b0;
    slot        = '0;
    for (int k = 0; k < PORTS; k++) begin
      // One extra bit so ptr+k never overflows before the modulo wrap.
      slot = {1'b0, ptr_q} + (IDXW + 1)'(k);
      if (slot >= (IDXW + 1)'(PORTS)) begin
        slot = slot - (IDXW + 1)'(PORTS);
      end
      if (!found && req_i[slot[IDXW-1:0]]) begin
        found                   = 1'b1;
        gnt_o[slot[IDXW-1:0]]   = 1'b1;
        gnt_idx_o               = slot[IDXW-1:0];
      end
    end
    gnt_valid_o = found;

    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_idx_o == IDXW'(PORTS - 1)) ? '0 : gnt_idx_o + IDXW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcc_circuit_allocator.sv
`default_nettype none
// ============================================================================
// Module      : pcc_circuit_allocator
// Description : PORTS x OUT_PORTS circuit allocator. Each output owns at most
//               one circuit, chosen round-robin among inputs with a valid
//               one-hot destination. Circuits end on release, on downstream
//               fail/cancel, or after TIMEOUT idle cycles (0 disables).
// Ports       : clk, reset (async, active-low)
//               req_valid_i/req_dest_i  setup requests (dest one-hot per input)
//               release_i, activity_i   per-input circuit end / flit moved
//               fail_i, cancel_i        per-output downstream kill
//               grant_o, deny_o         registered 1-cycle pulses per input
//               connections_o           bit i*OUT_PORTS+j: input i -> output j
//               occupied_o              output j owned by a circuit
// Revision    : 1.0 - initial release
// ============================================================================
module pcc_circuit_allocator
  import pcc_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int OUT_PORTS = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PORTS-1:0]            req_valid_i,
  input  logic [PORTS*OUT_PORTS-1:0]  req_dest_i,
  input  logic [PORTS-1:0]            release_i,
  input  logic [PORTS-1:0]            activity_i,
  input  logic [OUT_PORTS-1:0]        fail_i,
  input  logic [OUT_PORTS-1:0]        cancel_i,
  output logic [PORTS-1:0]            grant_o,
  output logic [PORTS-1:0]            deny_o,
  output logic [PORTS*OUT_PORTS-1:0]  connections_o,
  output logic [OUT_PORTS-1:0]        occupied_o
);

  localparam int OWNW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(TIMEOUT);
  // Timeout fires on the idle cycle that would carry the count to TIMEOUT,
  // so the deny appears after exactly TIMEOUT busy cycles.
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  out_state_e                    state_q [OUT_PORTS];
  out_state_e                    state_d [OUT_PORTS];
  logic [OUT_PORTS-1:0][OWNW-1:0] owner_q, owner_d;
  logic [OUT_PORTS-1:0][CNTW-1:0] cnt_q, cnt_d;
  logic [PORTS-1:0]              grant_q, grant_d;
  logic [PORTS-1:0]              deny_q, deny_d;

  logic [PORTS-1:0]              owns, eligible, malformed;
  logic [OUT_PORTS-1:0][PORTS-1:0] arb_req, arb_gnt;
  logic [OUT_PORTS-1:0][OWNW-1:0] arb_idx;
  logic [OUT_PORTS-1:0]          arb_valid;
  logic [OUT_PORTS-1:0]          timeout_hit;
  logic [PORTS-1:0]              owner_row [OUT_PORTS];

  // Request qualification. An input that saw grant/deny this cycle is
  // ignored so a still-high req_valid_i is not acted on twice.
  always_comb begin
    owns      = '0;
    eligible  = '0;
    malformed = '0;
    arb_req   = '0;
    for (int i = 0; i < PORTS; i++) begin
      for (int j = 0; j < OUT_PORTS; j++) begin
        if (state_q[j] == BUSY && owner_q[j] == OWNW'(i)) begin
          owns[i] = 1'b1;
        end
      end
      if (req_valid_i[i] && !owns[i] && !grant_q[i] && !deny_q[i]) begin
        if (is_onehot(32'(req_dest_i[i*OUT_PORTS +: OUT_PORTS]))) begin
          eligible[i] = 1'b1;
        end else begin
          malformed[i] = 1'b1;
        end
      end
    end
    for (int j = 0; j < OUT_PORTS; j++) begin
      for (int i = 0; i < PORTS; i++) begin
        arb_req[j][i] = eligible[i] && req_dest_i[i*OUT_PORTS + j] &&
                        (state_q[j] == IDLE);
      end
    end
  end

  for (genvar j = 0; j < OUT_PORTS; j++) begin : g_arb
    pcc_rr_arbiter #(
      .PORTS (PORTS),
      .IDXW  (OWNW)
    ) u_arb (
      .clk         (clk),
      .reset       (reset),
      .req_i       (arb_req[j]),
      .gnt_o       (arb_gnt[j]),
      .gnt_idx_o   (arb_idx[j]),
      .gnt_valid_o (arb_valid[j])
    );
  end

  always_comb begin
    timeout_hit = '0;
    for (int j = 0; j < OUT_PORTS; j++) begin
      timeout_hit[j] = (TIMEOUT > 0) && (state_q[j] == BUSY) &&
                       !activity_i[owner_q[j]] && (cnt_q[j] == CNT_LAST);
    end
  end

  // Per-output FSM. Kill (fail/cancel/timeout) outranks release, so a
  // simultaneous release still produces the deny.
  always_comb begin
    grant_d = '0;
    deny_d  = malformed;
    for (int j = 0; j < OUT_PORTS; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      cnt_d[j]   = cnt_q[j];
      case (state_q[j])
        IDLE: begin
          if (arb_valid[j]) begin
            state_d[j] = BUSY;
            owner_d[j] = arb_idx[j];
            cnt_d[j]   = '0;
            grant_d    = grant_d | arb_gnt[j];
          end
        end
        BUSY: begin
          if (fail_i[j] || cancel_i[j] || timeout_hit[j]) begin
            state_d[j]             = TEARDOWN;
            cnt_d[j]               = '0;
            deny_d[owner_q[j]]     = 1'b1;
          end else if (release_i[owner_q[j]]) begin
            state_d[j] = IDLE;
            cnt_d[j]   = '0;
          end else if (activity_i[owner_q[j]]) begin
            cnt_d[j] = '0;
          end else if (cnt_q[j] != CNT_MAX) begin
            cnt_d[j] = cnt_q[j] + CNTW'(1);
          end
        end
        TEARDOWN: state_d[j] = IDLE;
        default:  state_d[j] = IDLE;
      endcase
      if (TIMEOUT == 0) begin
        cnt_d[j] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q <= '0;
      deny_q  <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      for (int j = 0; j < OUT_PORTS; j++) begin
        state_q[j] <= IDLE;
      end
    end else begin
      grant_q <= grant_d;
      deny_q  <= deny_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      for (int j = 0; j < OUT_PORTS; j++) begin
        state_q[j] <= state_d[j];
      end
    end
  end

  // Crossbar matrix and occupancy follow directly from state/owner, so an
  // asynchronous reset clears them without waiting for a clock.
  always_comb begin
    connections_o = '0;
    occupied_o    = '0;
    for (int j = 0; j < OUT_PORTS; j++) begin
      occupied_o[j] = (state_q[j] == BUSY);
      owner_row[j]  = PORTS'(idx_to_onehot(32'(owner_q[j])));
      for (int i = 0; i < PORTS; i++) begin
        connections_o[i*OUT_PORTS + j] = occupied_o[j] && owner_row[j][i];
      end
    end
  end

  assign grant_o = grant_q;
  assign deny_o  = deny_q;

endmodule
`default_nettype wire

// File: tb/tb_pcc_circuit_allocator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pcc_circuit_allocator
// Description : Self-checking bench. A behavioural circuit-table model
//               predicts each cycle's outputs into a scoreboard queue; a
//               monitor pops and compares on every falling edge. Directed
//               scenarios add explicit constant checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcc_circuit_allocator;

  localparam int P  = 4;
  localparam int O  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [P-1:0]   req_valid_i = '0;
  logic [P*O-1:0] req_dest_i = '0;
  logic [P-1:0]   release_i = '0;
  logic [P-1:0]   activity_i = '0;
  logic [O-1:0]   fail_i = '0;
  logic [O-1:0]   cancel_i = '0;
  logic [P-1:0]   grant_o, deny_o;
  logic [P*O-1:0] connections_o;
  logic [O-1:0]   occupied_o;

  always #5 clk = ~clk;

  pcc_circuit_allocator #(.PORTS(P), .OUT_PORTS(O), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_dest_i    (req_dest_i),
    .release_i     (release_i),
    .activity_i    (activity_i),
    .fail_i        (fail_i),
    .cancel_i      (cancel_i),
    .grant_o       (grant_o),
    .deny_o        (deny_o),
    .connections_o (connections_o),
    .occupied_o    (occupied_o)
  );

  typedef struct packed {
    logic [P-1:0]   g;
    logic [P-1:0]   d;
    logic [P*O-1:0] c;
    logic [O-1:0]   o;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   deny_pulses = 0;

  // ---------------- reference model: table of circuits ----------------
  bit           m_busy [O];
  bit           m_td   [O];
  int           m_owner[O];
  int           m_idle [O];
  int           m_ptr  [O];
  logic [P-1:0] m_g = '0;
  logic [P-1:0] m_d = '0;

  task automatic model_clear();
    for (int j = 0; j < O; j++) begin
      m_busy[j] = 0; m_td[j] = 0; m_owner[j] = 0; m_idle[j] = 0; m_ptr[j] = 0;
    end
    m_g = '0;
    m_d = '0;
  endtask

  always @(negedge reset) model_clear();

  always @(posedge clk) begin : model
    exp_t         e;
    logic [P-1:0] ng, nd;
    logic [O-1:0] dest;
    bit           owns [P];
    bit           pend [P];
    int           tgt  [P];
    int           o, cand;
    bit           kill, done;
    if (!reset) begin
      model_clear();
      exp_q.push_back('0);
    end else begin
      ng = '0;
      nd = '0;
      for (int i = 0; i < P; i++) begin
        owns[i] = 0;
        for (int j = 0; j < O; j++) if (m_busy[j] && m_owner[j] == i) owns[i] = 1;
        dest    = req_dest_i[i*O +: O];
        pend[i] = req_valid_i[i] && !owns[i] && !m_g[i] && !m_d[i];
        tgt[i]  = -1;
        if ($countones(dest) == 1)
          for (int j = 0; j < O; j++) if (dest[j]) tgt[i] = j;
        if (pend[i] && tgt[i] < 0) nd[i] = 1'b1;
      end
      for (int j = 0; j < O; j++) begin
        if (m_busy[j]) begin
          o    = m_owner[j];
          kill = fail_i[j] || cancel_i[j] || (!activity_i[o] && m_idle[j] + 1 >= TO);
          if (kill) begin
            m_busy[j] = 0; m_td[j] = 1; nd[o] = 1'b1;
          end else if (release_i[o]) begin
            m_busy[j] = 0;
          end else begin
            m_idle[j] = activity_i[o] ? 0 : m_idle[j] + 1;
          end
        end else if (m_td[j]) begin
          m_td[j] = 0;
        end else begin
          done = 0;
          for (int k = 0; k < P; k++) begin
            cand = (m_ptr[j] + k) % P;
            if (!done && pend[cand] && tgt[cand] == j) begin
              done = 1;
              m_busy[j] = 1; m_owner[j] = cand; m_idle[j] = 0;
              m_ptr[j] = (cand + 1) % P;
              ng[cand] = 1'b1;
            end
          end
        end
      end
      e.g = ng;
      e.d = nd;
      e.c = '0;
      e.o = '0;
      for (int j = 0; j < O; j++) begin
        if (m_busy[j]) begin
          e.c[m_owner[j]*O + j] = 1'b1;
          e.o[j] = 1'b1;
        end
      end
      m_g = ng;
      m_d = nd;
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!reset) e = '0;
      a = {grant_o, deny_o, connections_o, occupied_o};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL scoreboard @%0t: got g=%b d=%b c=%h o=%b, expected g=%b d=%b c=%h o=%b",
                 $time, a.g, a.d, a.c, a.o, e.g, e.d, e.c, e.o);
      end
      checks++;
      if ((grant_o & deny_o) !== '0) begin
        fails++;
        $display("FAIL grant_deny_exclusive @%0t: got overlap %b, expected 0", $time, grant_o & deny_o);
      end
    end
    if (reset && deny_o != '0) deny_pulses++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dest(input int i, input logic [O-1:0] v);
    req_dest_i[i*O +: O] = v;
  endtask

  task automatic clear_inputs();
    req_valid_i = '0; req_dest_i = '0; release_i = '0;
    activity_i = '0; fail_i = '0; cancel_i = '0;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic wait_grant(input string name);
    bit seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      if (grant_o != '0) seen = 1;
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL %s: got no grant within 20 cycles, expected a grant", name);
    end
  endtask

  function automatic logic [O-1:0] rand_dest();
    int r = $urandom_range(0, 9);
    logic [O-1:0] v;
    if (r == 0)      v = '0;
    else if (r == 1) v = O'($urandom);
    else             v = O'(1) << $urandom_range(0, O - 1);
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int order [5] = '{0, 1, 2, 3, 0};
    logic [P-1:0] deny_any;

    // 1: reset holds outputs low under random inputs, then first grant
    reset = 1'b0;
    repeat (4) begin
      step();
      req_valid_i = P'($urandom); req_dest_i = (P*O)'($urandom);
      release_i = P'($urandom); activity_i = P'($urandom);
      fail_i = O'($urandom); cancel_i = O'($urandom);
    end
    check("reset_outputs", 32'({grant_o, deny_o, connections_o, occupied_o}), 32'd0);
    clear_inputs();
    reset = 1'b1;
    req_valid_i[1] = 1'b1;
    set_dest(1, 4'b0100);
    step();
    check("first_grant", 32'(grant_o), 32'h2);
    check("first_conn", 32'(connections_o), 32'h0040);
    check("first_occ", 32'(occupied_o), 32'h4);
    req_valid_i = '0;
    step();
    release_i[1] = 1'b1;
    step();
    release_i = '0;
    check("release_clears_occ", 32'(occupied_o), 32'h0);

    // 2: round-robin fairness on output 2
    reset_pulse();
    deny_pulses = 0;
    req_valid_i = '1;
    for (int i = 0; i < P; i++) set_dest(i, 4'b0100);
    for (int n = 0; n < 5; n++) begin
      wait_grant("fair_wait");
      check("fair_grant", 32'(grant_o), 32'(1) << order[n]);
      req_valid_i[order[n]] = 1'b0;
      repeat (3) step();
      release_i[order[n]] = 1'b1;
      if (n == 0) req_valid_i[0] = 1'b1;
      step();
      release_i = '0;
    end
    check("fair_no_deny", 32'(deny_pulses), 32'd0);
    clear_inputs();
    step();

    // 3: malformed destinations
    req_valid_i[0] = 1'b1;
    set_dest(0, 4'b0011);
    step();
    check("multihot_deny", 32'(deny_o), 32'h1);
    check("multihot_conn", 32'(connections_o), 32'h0);
    clear_inputs();
    step();
    req_valid_i[2] = 1'b1;
    set_dest(2, 4'b0000);
    step();
    check("zero_dest_deny", 32'(deny_o), 32'h4);
    check("zero_dest_conn", 32'(connections_o), 32'h0);
    clear_inputs();
    step();

    // 4: fail with simultaneous release, pending input waits out teardown
    req_valid_i[3] = 1'b1;
    set_dest(3, 4'b0001);
    step();
    check("td_setup_grant", 32'(grant_o), 32'h8);
    req_valid_i[3] = 1'b0;
    req_valid_i[1] = 1'b1;
    set_dest(1, 4'b0001);
    step();
    fail_i = 4'b0001;
    release_i[3] = 1'b1;
    step();
    fail_i = '0;
    release_i = '0;
    check("td_deny", 32'(deny_o), 32'h8);
    check("td_occ0", 32'(occupied_o[0]), 32'h0);
    check("td_no_grant_yet", 32'(grant_o), 32'h0);
    step();
    check("td_still_no_grant", 32'(grant_o), 32'h0);
    step();
    check("td_pending_grant", 32'(grant_o), 32'h2);
    req_valid_i = '0;
    release_i[1] = 1'b1;
    step();
    release_i = '0;

    // 5: idle timeout, then activity keeps the circuit alive
    reset_pulse();
    req_valid_i[0] = 1'b1;
    set_dest(0, 4'b0010);
    step();
    check("to_grant", 32'(grant_o), 32'h1);
    req_valid_i = '0;
    for (int k = 1; k < TO; k++) begin
      step();
      check("to_hold", 32'({deny_o, occupied_o}), 32'h02);
    end
    step();
    check("to_deny", 32'({deny_o, occupied_o}), 32'h10);
    step();
    req_valid_i[0] = 1'b1;
    step();
    check("alive_grant", 32'(grant_o), 32'h1);
    req_valid_i = '0;
    deny_any = '0;
    for (int c = 1; c <= 100; c++) begin
      activity_i[0] = (c % 5 == 0);
      step();
      deny_any = deny_any | deny_o;
    end
    check("alive_no_deny", 32'(deny_any), 32'h0);
    check("alive_occ", 32'(occupied_o), 32'h2);
    activity_i = '0;
    release_i[0] = 1'b1;
    step();
    release_i = '0;

    // 6: async reset with two circuits live; pointers restart at 0
    req_valid_i = 4'b1100;
    set_dest(2, 4'b0001);
    set_dest(3, 4'b0010);
    step();
    check("ar_grants", 32'(grant_o), 32'hC);
    check("ar_occ", 32'(occupied_o), 32'h3);
    req_valid_i = '0;
    step();
    #2;
    reset = 1'b0;
    #1;
    check("ar_conn_cleared", 32'(connections_o), 32'h0);
    check("ar_occ_cleared", 32'(occupied_o), 32'h0);
    step();
    reset = 1'b1;
    req_valid_i = '1;
    for (int i = 0; i < P; i++) set_dest(i, 4'b0001);
    step();
    check("ar_ptr_restart", 32'(grant_o), 32'h1);
    clear_inputs();
    release_i[0] = 1'b1;
    step();
    release_i = '0;

    // random traffic checked by the scoreboard only
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < P; i++) begin
        if ($urandom_range(0, 3) == 0) req_valid_i[i] = ~req_valid_i[i];
        if ($urandom_range(0, 3) == 0) set_dest(i, rand_dest());
      end
      release_i  = P'($urandom & $urandom & $urandom);
      activity_i = P'($urandom & $urandom & $urandom);
      fail_i     = ($urandom_range(0, 15) == 0) ? O'($urandom) : '0;
      cancel_i   = ($urandom_range(0, 15) == 0) ? O'($urandom) : '0;
      step();
    end
    clear_inputs();
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
